alsu_pipe: RTL and testbench

//  Parametrised, pipelined successor to the team's 3-bit ALSU.

---
 rtl/alsu_pipe.sv | 148 ++++++++++++++
 tb/tb_alsu_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage pipelined ALSU (AND/XOR/ADD/MULT/SHIFT/ROTATE) with an error LED blinker.
// Optional feature: define ALSU_ERR_CNT_EN to add the saturating err_cnt output.
module alsu_pipe #(
   parameter int WIDTH          = 3,
   parameter     INPUT_PRIORITY = "A",
   parameter bit FULL_ADDER     = 1'b1,
   parameter int LEDS_W         = 16,
   parameter int BLINK_DIV      = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_in,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [2:0]           opcode,
   input  logic                 cin,
   input  logic                 serial_in,
   input  logic                 direction,
   input  logic                 red_op_A,
   input  logic                 red_op_B,
   input  logic                 bypass_A,
   input  logic                 bypass_B,
   output logic                 valid_out,
   output logic [2*WIDTH-1:0]   out,
   output logic                 err,
`ifdef ALSU_ERR_CNT_EN
   output logic [7:0]           err_cnt,
`endif
   output logic [LEDS_W-1:0]    leds
);

   localparam int OW     = 2 * WIDTH;
   localparam bit PRIO_B = (INPUT_PRIORITY == "B");
   localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

   logic [WIDTH-1:0] a_reg, b_reg;
   logic [2:0]       op_reg;
   logic             cin_reg, ser_reg, dir_reg;
   logic             red_a_reg, red_b_reg, byp_a_reg, byp_b_reg;
   logic             v1_reg;
   logic [CNT_W-1:0] blink_cnt_reg;

   logic [OW-1:0]    a_ext, b_ext, carry, sum, prod, red_ext, result_next;
   logic [WIDTH-1:0] red_src;
   logic             red_bit, reducing, invalid, err_next;

   assign a_ext    = {{WIDTH{1'b0}}, a_reg};
   assign b_ext    = {{WIDTH{1'b0}}, b_reg};
   assign carry    = FULL_ADDER ? {{(OW-1){1'b0}}, cin_reg} : '0;
   assign sum      = a_ext + b_ext + carry;
   assign prod     = a_ext * b_ext;
   assign reducing = red_a_reg | red_b_reg;

   // With both reduce flags set, the preferred operand is reduced.
   assign red_src  = (red_a_reg && red_b_reg) ? (PRIO_B ? b_reg : a_reg)
                   : (red_a_reg ? a_reg : b_reg);
   assign red_bit  = op_reg[0] ? ^red_src : &red_src;
   assign red_ext  = {{(OW-1){1'b0}}, red_bit};
   assign invalid  = (op_reg[2] & op_reg[1]) | (reducing & (op_reg[2:1] != 2'b00));

   always_comb begin
      result_next = out;
      err_next    = 1'b0;
      if (byp_a_reg && byp_b_reg) begin
         result_next = PRIO_B ? b_ext : a_ext;
      end else if (byp_a_reg) begin
         result_next = a_ext;
      end else if (byp_b_reg) begin
         result_next = b_ext;
      end else if (invalid) begin
         result_next = '0;
         err_next    = 1'b1;
      end else begin
         case (op_reg)
            3'b000:  result_next = reducing ? red_ext : (a_ext & b_ext);
            3'b001:  result_next = reducing ? red_ext : (a_ext ^ b_ext);
            3'b010:  result_next = sum;
            3'b011:  result_next = prod;
            3'b100:  result_next = dir_reg ? {out[OW-2:0], ser_reg} : {ser_reg, out[OW-1:1]};
            3'b101:  result_next = dir_reg ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
            default: result_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg         <= '0;
         b_reg         <= '0;
         op_reg        <= '0;
         cin_reg       <= 1'b0;
         ser_reg       <= 1'b0;
         dir_reg       <= 1'b0;
         red_a_reg     <= 1'b0;
         red_b_reg     <= 1'b0;
         byp_a_reg     <= 1'b0;
         byp_b_reg     <= 1'b0;
         v1_reg        <= 1'b0;
         valid_out     <= 1'b0;
         out           <= '0;
         err           <= 1'b0;
         leds          <= '0;
         blink_cnt_reg <= '0;
      end else begin
         v1_reg    <= valid_in;
         valid_out <= v1_reg;
         if (valid_in) begin
            a_reg     <= A;
            b_reg     <= B;
            op_reg    <= opcode;
            cin_reg   <= cin;
            ser_reg   <= serial_in;
            dir_reg   <= direction;
            red_a_reg <= red_op_A;
            red_b_reg <= red_op_B;
            byp_a_reg <= bypass_A;
            byp_b_reg <= bypass_B;
         end
         if (v1_reg) begin
            out <= result_next;
            err <= err_next;
         end
         // A good op silences the blinker; otherwise it free-runs while err is held.
         if (v1_reg && !err_next) begin
            leds          <= '0;
            blink_cnt_reg <= '0;
         end else if (err) begin
            if (blink_cnt_reg == CNT_LAST) begin
               blink_cnt_reg <= '0;
               leds          <= ~leds;
            end else begin
               blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
         end
      end
   end

`ifdef ALSU_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= '0;
      else if (v1_reg && err_next && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_alsu_pipe.sv
// Self-checking bench for alsu_pipe: directed scenarios plus randomized traffic vs. an arithmetic model.
module tb_alsu_pipe;
   localparam int W   = 3;
   localparam int OW  = 2 * W;
   localparam int LW  = 16;
   localparam int DIV = 4;

   logic clk = 1'b0, rst_n = 1'b1, valid_in = 1'b0;
   logic [W-1:0] A = '0, B = '0;
   logic [2:0] opcode = '0;
   logic cin = 0, serial_in = 0, direction = 0, red_op_A = 0, red_op_B = 0, bypass_A = 0, bypass_B = 0;
   logic valid_out, err;
   logic [OW-1:0] out;
   logic [LW-1:0] leds;
`ifdef ALSU_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER(1'b1), .LEDS_W(LW), .BLINK_DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .A(A), .B(B), .opcode(opcode), .cin(cin),
      .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
      .bypass_A(bypass_A), .bypass_B(bypass_B), .valid_out(valid_out), .out(out), .err(err),
`ifdef ALSU_ERR_CNT_EN
      .err_cnt(err_cnt),
`endif
      .leds(leds));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic d,
                        input logic ra, input logic rb, input logic ba, input logic bb);
      valid_in = 1'b1; opcode = op; A = a; B = b; cin = c; serial_in = s; direction = d;
      red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
   endtask

   // Drive one op for a single edge, then idle the inputs.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic d,
                        input logic ra, input logic rb, input logic ba, input logic bb);
      drive(op, a, b, c, s, d, ra, rb, ba, bb);
      tick();
      valid_in = 1'b0; red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0;
   endtask

   // Reference: result of one accepted op given the previous output value.
   function automatic void ref_op(input int op, input int a, input int b, input bit c, input bit s,
                                  input bit d, input bit ra, input bit rb, input bit ba, input bit bb,
                                  inout int o, output bit e);
      int x;
      e = 1'b0;
      if (ba) o = a;
      else if (bb) o = b;
      else if (op >= 6 || ((ra || rb) && op >= 2)) begin
         o = 0;
         e = 1'b1;
      end else begin
         case (op)
            0, 1: begin
               if (ra || rb) begin
                  x = ra ? a : b;
                  o = (op == 0) ? int'(x == (1 << W) - 1) : ($countones(x) % 2);
               end else begin
                  o = (op == 0) ? (a & b) : (a ^ b);
               end
            end
            2: o = a + b + int'(c);
            3: o = a * b;
            4: o = d ? ((o * 2) % (1 << OW) + int'(s)) : (o / 2 + int'(s) * (1 << (OW - 1)));
            default: o = d ? ((o * 2) % (1 << OW) + o / (1 << (OW - 1)))
                           : (o / 2 + (o % 2) * (1 << (OW - 1)));
         endcase
      end
   endfunction

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %0h want 0", out); end
      n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_tests++; if (leds !== '0) begin n_fail++; $display("FAIL reset_leds: got %0h want 0", leds); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      n_tests++; if (valid_out !== 1'b0 || out !== '0) begin
         n_fail++; $display("FAIL reset_release: got v=%b out=%0h want v=0 out=0", valid_out, out);
      end
      $display("[TB] reset: checked");
   endtask

   task automatic test_mult_latency;
      issue(3'b011, 3'd5, 3'd3, 0, 0, 0, 0, 0, 0, 0);
      n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mult_early: valid_out got %b want 0", valid_out); end
      tick();
      n_tests++; if (valid_out !== 1'b1 || out !== 6'd15 || err !== 1'b0) begin
         n_fail++; $display("FAIL mult_result: got v=%b out=%0d err=%b want v=1 out=15 err=0", valid_out, out, err);
      end
      tick();
      n_tests++; if (valid_out !== 1'b0 || out !== 6'd15) begin
         n_fail++; $display("FAIL mult_hold: got v=%b out=%0d want v=0 out=15", valid_out, out);
      end
      $display("[TB] mult 5*3: out=%0d", out);
   endtask

   task automatic test_add;
      issue(3'b010, 3'd7, 3'd7, 1, 0, 0, 0, 0, 0, 0);
      tick();
      n_tests++; if (valid_out !== 1'b1 || out !== 6'd15) begin
         n_fail++; $display("FAIL add_cin: got v=%b out=%0d want v=1 out=15", valid_out, out);
      end
      $display("[TB] add 7+7+1: out=%0d", out);
   endtask

   task automatic test_shift_rotate;
      issue(3'b100, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0);
      tick();
      n_tests++; if (out !== 6'b011110) begin n_fail++; $display("FAIL shift_left: got %b want 011110", out); end
      issue(3'b101, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_tests++; if (out !== 6'b001111) begin n_fail++; $display("FAIL rotate_right: got %b want 001111", out); end
      $display("[TB] shift/rotate: out=%b", out);
   endtask

   task automatic test_reduction_bypass;
      issue(3'b001, 3'b111, 3'b001, 0, 0, 0, 1, 1, 0, 0);
      tick();
      n_tests++; if (out !== 6'd1 || err !== 1'b0) begin
         n_fail++; $display("FAIL xor_red_both: got out=%0d err=%b want out=1 err=0", out, err);
      end
      issue(3'b000, 3'b110, 3'b111, 0, 0, 0, 0, 1, 0, 0);
      tick();
      n_tests++; if (out !== 6'd1) begin n_fail++; $display("FAIL and_red_b: got %0d want 1", out); end
      issue(3'b111, 3'd6, 3'd2, 0, 0, 0, 0, 0, 1, 1);
      tick();
      n_tests++; if (out !== 6'd6 || err !== 1'b0) begin
         n_fail++; $display("FAIL bypass_both: got out=%0d err=%b want out=6 err=0", out, err);
      end
      issue(3'b010, 3'd3, 3'd4, 0, 0, 0, 1, 0, 0, 0);
      tick();
      n_tests++; if (out !== '0 || err !== 1'b1 || valid_out !== 1'b1) begin
         n_fail++; $display("FAIL add_reduce_invalid: got out=%0d err=%b v=%b want out=0 err=1 v=1", out, err, valid_out);
      end
      issue(3'b110, 3'd1, 3'd5, 0, 0, 0, 0, 0, 0, 1);
      tick();
      n_tests++; if (out !== 6'd5 || err !== 1'b0) begin
         n_fail++; $display("FAIL bypass_b_invalid_op: got out=%0d err=%b want out=5 err=0", out, err);
      end
      $display("[TB] reduction/bypass: last out=%0d", out);
   endtask

   task automatic test_invalid_blink;
      issue(3'b110, 3'd5, 3'd3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_tests++; if (out !== '0 || err !== 1'b1 || leds !== '0) begin
         n_fail++; $display("FAIL invalid_op: got out=%0d err=%b leds=%0h want 0 1 0", out, err, leds);
      end
      for (int i = 1; i <= 2 * DIV; i++) begin
         tick();
         n_tests++;
         if (leds !== ((i >= DIV && i < 2 * DIV) ? 16'hFFFF : 16'h0000)) begin
            n_fail++; $display("FAIL blink_%0d: got %0h want %0h", i, leds,
                               (i >= DIV && i < 2 * DIV) ? 16'hFFFF : 16'h0000);
         end
      end
      issue(3'b000, 3'd5, 3'd3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_tests++; if (err !== 1'b0 || leds !== '0 || out !== 6'd1) begin
         n_fail++; $display("FAIL err_clear: got err=%b leds=%0h out=%0d want 0 0 1", err, leds, out);
      end
      $display("[TB] invalid blink: cleared err=%b", err);
   endtask

   task automatic test_reset_midstream;
      issue(3'b011, 3'd5, 3'd3, 0, 0, 0, 0, 0, 0, 0);
      drive(3'b011, 3'd7, 3'd7, 0, 0, 0, 0, 0, 0, 0);
      tick();
      valid_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (out !== '0 || valid_out !== 1'b0) begin
         n_fail++; $display("FAIL midreset_async: got out=%0d v=%b want 0 0", out, valid_out);
      end
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (valid_out !== 1'b0 || out !== '0) begin
            n_fail++; $display("FAIL midreset_dropped_%0d: got v=%b out=%0d want 0 0", i, valid_out, out);
         end
      end
      issue(3'b111, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i <= DIV; i++) tick();
      n_tests++; if (leds !== 16'hFFFF || err !== 1'b1) begin
         n_fail++; $display("FAIL midreset_preblink: got leds=%0h err=%b want ffff 1", leds, err);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (leds !== '0 || err !== 1'b0) begin
         n_fail++; $display("FAIL midreset_leds: got leds=%0h err=%b want 0 0", leds, err);
      end
      #2 rst_n = 1'b1;
      tick();
      $display("[TB] mid-stream reset: out=%0d leds=%0h", out, leds);
   endtask

   typedef struct {
      int due;
      int o;
      bit e;
   } exp_t;

   task automatic test_random_back_to_back;
      exp_t q[$];
      exp_t ex;
      int cyc = 0, model_out = 0, cur_out = 0, rise = 0, ecount = 0;
      bit cur_err = 1'b0, exp_v, e;
      logic [LW-1:0] exp_leds;
      int op, a, b;
      bit c, s, d, ra, rb, ba, bb;
      for (int i = 0; i < 400; i++) begin
         if (i < 396 && $urandom_range(0, 3) != 0) begin
            op = $urandom_range(0, 7); a = $urandom_range(0, 7); b = $urandom_range(0, 7);
            c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 5) == 0); rb = ($urandom_range(0, 5) == 0);
            ba = ($urandom_range(0, 9) == 0); bb = ($urandom_range(0, 9) == 0);
            drive(3'(op), W'(a), W'(b), c, s, d, ra, rb, ba, bb);
            ref_op(op, a, b, c, s, d, ra, rb, ba, bb, model_out, e);
            ex.due = cyc + 2; ex.o = model_out; ex.e = e;
            q.push_back(ex);
         end else begin
            valid_in = 1'b0;
         end
         tick();
         cyc++;
         exp_v = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            ex = q.pop_front();
            exp_v = 1'b1;
            cur_out = ex.o;
            if (ex.e && !cur_err) rise = cyc;
            if (ex.e && ecount < 255) ecount++;
            cur_err = ex.e;
         end
         exp_leds = (cur_err && (((cyc - rise) / DIV) % 2 == 1)) ? '1 : '0;
         n_tests++;
         if (valid_out !== exp_v || out !== OW'(cur_out) || err !== cur_err || leds !== exp_leds) begin
            n_fail++;
            $display("FAIL rand_cyc%0d: got v=%b out=%0d err=%b leds=%0h want v=%b out=%0d err=%b leds=%0h",
                     cyc, valid_out, out, err, leds, exp_v, cur_out, cur_err, exp_leds);
         end
`ifdef ALSU_ERR_CNT_EN
         n_tests++;
         if (err_cnt !== 8'(ecount)) begin
            n_fail++; $display("FAIL rand_errcnt_cyc%0d: got %0d want %0d", cyc, err_cnt, ecount);
         end
`endif
      end
      $display("[TB] random back-to-back: %0d cycles, final out=%0d", cyc, out);
   endtask

   initial begin
      test_reset();
      test_mult_latency();
      test_add();
      test_shift_rotate();
      test_reduction_bypass();
      test_invalid_blink();
      test_reset_midstream();
      test_random_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
